// File: rtl/pyc_sram_pipe.sv
// Pipelined, multi-outstanding word SRAM with byte strobes and in-order responses.
// Read data is sampled at accept, walks a fixed-latency pipe, then a small reorder-free queue.
module pyc_sram_pipe #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 1024,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WRITE_RESP      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic                        req_write,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic [(DATA_WIDTH+7)/8-1:0] req_wstrb,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_WIDTH-1:0]       resp_rdata,
    output logic                        resp_err,
    output logic                        resp_write
);
    localparam int L  = READ_LATENCY;
    localparam int M  = MAX_OUTSTANDING;
    localparam int CW = $clog2(M + 1);
    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(M);
    localparam logic [PW-1:0] PTR_LAST = PW'(M - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         cnt_q, cnt_d, qcnt_q, qcnt_d;
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [L-1:0]          pv_q, pv_d, perr_q, perr_d, pwr_q, pwr_d;
    logic [DATA_WIDTH-1:0] pdata_q [L];
    logic [DATA_WIDTH-1:0] pdata_d [L];
    logic [DATA_WIDTH-1:0] qdata [M];
    logic [M-1:0]          qerr, qwr;

    logic                  in_range, accept, gen, fire;
    logic                  q_empty, q_full, q_push, q_pop;
    logic [DATA_WIDTH-1:0] rd_word;

    // Compare at full width so out-of-range addresses never alias into the array.
    assign in_range = (32'(req_addr) < 32'(DEPTH));

    always_comb begin
        rd_word    = in_range ? mem[req_addr] : '0;
        q_empty    = (qcnt_q == '0);
        q_full     = (qcnt_q == CNT_MAX);

        // Oldest response is the queue head; an empty queue lets the pipe tail through directly.
        resp_valid = !q_empty || pv_q[L-1];
        resp_rdata = '0;
        resp_err   = 1'b0;
        resp_write = 1'b0;
        if (!q_empty) begin
            resp_rdata = qdata[rp_q];
            resp_err   = qerr[rp_q];
            resp_write = qwr[rp_q];
        end else if (pv_q[L-1]) begin
            resp_rdata = pdata_q[L-1];
            resp_err   = perr_q[L-1];
            resp_write = pwr_q[L-1];
        end

        fire      = resp_valid && resp_ready;
        req_ready = (cnt_q < CNT_MAX) || fire;
        accept    = req_valid && req_ready;
        gen       = accept && (!req_write || (WRITE_RESP != 0));
        q_push    = pv_q[L-1] && !(q_empty && resp_ready);
        q_pop     = fire && !q_empty;

        cnt_d = cnt_q;
        if (gen && !fire)      cnt_d = cnt_q + CW'(1);
        else if (!gen && fire) cnt_d = cnt_q - CW'(1);

        qcnt_d = qcnt_q;
        if (q_push && !q_pop)      qcnt_d = qcnt_q + CW'(1);
        else if (!q_push && q_pop) qcnt_d = qcnt_q - CW'(1);

        wp_d = wp_q;
        if (q_push) wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + PW'(1);
        rp_d = rp_q;
        if (q_pop)  rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + PW'(1);

        pv_d[0]    = gen;
        pdata_d[0] = req_write ? '0 : rd_word;
        perr_d[0]  = !in_range;
        pwr_d[0]   = req_write;
        for (int i = 1; i < L; i++) begin
            pv_d[i]    = pv_q[i-1];
            pdata_d[i] = pdata_q[i-1];
            perr_d[i]  = perr_q[i-1];
            pwr_d[i]   = pwr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            qcnt_q <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            pv_q   <= '0;
            perr_q <= '0;
            pwr_q  <= '0;
            for (int i = 0; i < L; i++) pdata_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            qcnt_q <= qcnt_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            pv_q   <= pv_d;
            perr_q <= perr_d;
            pwr_q  <= pwr_d;
            for (int i = 0; i < L; i++) pdata_q[i] <= pdata_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_write && in_range) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (req_wstrb[b/8]) mem[req_addr][b] <= req_wdata[b];
            end
        end
        if (q_push) begin
            qdata[wp_q] <= pdata_q[L-1];
            qerr[wp_q]  <= perr_q[L-1];
            qwr[wp_q]   <= pwr_q[L-1];
        end
    end

    a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(q_push && q_full));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(q_pop && q_empty));
    a_cnt_bounded:   assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_MAX);
endmodule

// File: tb/tb_pyc_sram_pipe.sv
// Randomized and directed bench for pyc_sram_pipe against a transaction-level model.
module tb_pyc_sram_pipe;
    localparam int A_L     = 2;
    localparam int A_MAX   = 4;
    localparam int A_DEPTH = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, resp_ready;
    logic        req_ready, resp_valid, resp_err, resp_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        b_req_valid, b_req_write, b_resp_ready;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_resp_write;
    logic [9:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_wstrb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        wr;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [1024];

    pyc_sram_pipe #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(A_DEPTH), .READ_LATENCY(A_L),
                    .MAX_OUTSTANDING(A_MAX), .WRITE_RESP(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_write(resp_write));

    pyc_sram_pipe #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1),
                    .MAX_OUTSTANDING(2), .WRITE_RESP(0)) u_nwr (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_write(b_req_write), .req_wdata(b_req_wdata),
        .req_wstrb(b_req_wstrb), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .resp_write(b_resp_write));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle on DUT A: drive at negedge, compare against the model, then retire/enqueue.
    task automatic step(input logic v, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic rr);
        logic exp_valid, fire, exp_ready;
        exp_t e;
        @(negedge clk);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        resp_ready = rr;
        #1;
        exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
        check_eq("resp_valid", resp_valid, exp_valid);
        if (exp_valid) begin
            check_eq("resp_rdata", resp_rdata, exp_q[0].data);
            check_eq("resp_err", resp_err, exp_q[0].err);
            check_eq("resp_write", resp_write, exp_q[0].wr);
        end
        fire      = exp_valid && rr;
        exp_ready = (exp_q.size() < A_MAX) || fire;
        check_eq("req_ready", req_ready, exp_ready);
        if (fire) void'(exp_q.pop_front());
        if (v && exp_ready) begin
            e.err  = (int'(a) >= A_DEPTH);
            e.wr   = w;
            e.due  = cyc + A_L;
            e.data = '0;
            if (!w && !e.err) e.data = ref_mem[a];
            if (w && !e.err)
                for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_resp_valid"}, resp_valid, 1'b0);
        check_eq({pfx, "_resp_rdata"}, resp_rdata, 32'd0);
        check_eq({pfx, "_resp_err"}, resp_err, 1'b0);
        check_eq({pfx, "_resp_write"}, resp_write, 1'b0);
        check_eq({pfx, "_req_ready"}, req_ready, 1'b1);
    endtask

    logic [31:0] b_exp [3];
    logic [9:0]  b_addr_tab [5];
    logic        b_wr_tab [5];
    logic [31:0] b_data_tab [5];
    int          b_n;

    initial begin
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0;
        b_resp_ready = 1;
        #1;
        check_reset_outputs("rst");
        check_eq("b_rst_resp_valid", b_resp_valid, 1'b0);
        check_eq("b_rst_req_ready", b_req_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 10'(a), $urandom, 4'hF, 1'b1);
        idle(4);

        // Full write then read-back, then masked overwrite.
        step(1'b1, 1'b1, 10'd5, 32'h1234_5678, 4'hF, 1'b1);
        step(1'b1, 1'b0, 10'd5, 32'd0, 4'h0, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 10'd5, 32'hAABB_CCDD, 4'b0101, 1'b1);
        step(1'b1, 1'b0, 10'd5, 32'd0, 4'h0, 1'b1);
        idle(3);
        check_eq("masked_ref", ref_mem[5], 32'h12BB_56DD);

        // Credit exhaustion under backpressure, then release while still requesting.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'(i), 32'd0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'(8 + i), 32'd0, 4'h0, 1'b1);
        idle(6);

        // Out-of-range write must not land anywhere.
        step(1'b1, 1'b1, 10'd1010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        step(1'b1, 1'b0, 10'd1010, 32'd0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 10'd10, 32'd0, 4'h0, 1'b1);
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 10'(a), 32'd0, 4'h0, 1'b1);
        idle(4);

        for (int i = 0; i < 400; i++) begin
            logic [9:0] a;
            a = ($urandom_range(0, 7) == 0) ? 10'(1000 + $urandom_range(0, 23))
                                            : 10'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        idle(10);

        // Reset with reads in flight: everything outstanding is dropped, memory survives.
        step(1'b1, 1'b1, 10'd4, 32'h5A5A_0F0F, 4'hF, 1'b1);
        idle(3);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 10'(i), 32'd0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        step(1'b1, 1'b0, 10'd4, 32'd0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 10'd1, 32'd0, 4'h0, 1'b1);
        idle(4);

        // Silent writes on the second instance.
        b_addr_tab = '{10'd7, 10'd7, 10'd7, 10'd8, 10'd8};
        b_wr_tab   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        b_data_tab = '{32'd0, 32'hCAFE_F00D, 32'd0, 32'h0BAD_BEEF, 32'd0};
        b_exp      = '{32'd0, 32'hCAFE_F00D, 32'h0BAD_BEEF};
        b_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_req_valid = (i < 5);
            b_req_write = (i < 5) ? b_wr_tab[i] : 1'b0;
            b_req_addr  = (i < 5) ? b_addr_tab[i] : 10'd0;
            b_req_wdata = (i < 5) ? b_data_tab[i] : 32'd0;
            b_req_wstrb = 4'hF;
            #1;
            check_eq("b_req_ready", b_req_ready, 1'b1);
            if (b_resp_valid) begin
                check_eq("b_resp_write", b_resp_write, 1'b0);
                if (b_n == 1 || b_n == 2) check_eq("b_resp_rdata", b_resp_rdata, b_exp[b_n]);
                b_n++;
            end
        end
        b_req_valid = 1'b0;
        check_eq("b_resp_count", 32'(b_n), 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
